load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage front end of the pipelined processor. It sits between the EX/MEM pipeline register and the word-addressed data memory.
- Accepts one load/store request at a time via valid/ready and drives the memory's memread/memwrite/address/writedata.
- Performs byte/halfword stores as read-modify-write, and sign/zero-extends sub-word loads.
- Flags misaligned or out-of-range accesses instead of issuing them; returns one response per request toward MEM/WB.

Parameters:
- MEM_WORDS, 128, number of 32-bit words in the data memory; word indices >= MEM_WORDS fault.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_load  in  1  1 = load, 0 = store.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_rd  in  5  destination register tag, passed through.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_rd  out  5  tag of the responding request.
- resp_fault  out  1  request was misaligned, illegal size or out of range.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_address  out  32  word index = req_addr[31:2].
- mem_writedata  out  32  word written to memory.
- mem_readdata  in  32  memory read data, combinational from mem_address.

Behaviour:
- Registered outputs:
  - All outputs are flop-driven; mem_read/mem_write must be glitch-free because the memory writes on level.
  - Reset values: req_ready 1; resp_valid, resp_fault, mem_read, mem_write 0; resp_rdata, resp_rd, mem_address, mem_writedata 0.
- States: IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, RESP.
- IDLE:
  - On req_valid & req_ready, register the request.
  - Fault check: half with addr[0]=1; word with addr[1:0]!=0; size 11; or addr[31:2] >= MEM_WORDS.
  - Fault -> RESP with resp_fault=1, rdata 0, no memory strobe ever asserted.
  - Else load -> LOAD; word store -> ST_WORD; byte/half store -> RMW_RD.
  - req_ready drops on the accepting edge.
- LOAD:
  - mem_read=1 and mem_address=index for exactly this cycle.
  - At the end of the cycle, select the lane by addr[1:0] (little-endian: lane 0 = bits [7:0]), extend, register into resp_rdata. -> RESP.
- ST_WORD: mem_write=1, mem_writedata=req_wdata for one cycle. -> RESP.
- RMW_RD: mem_read=1; capture mem_readdata. -> RMW_WR.
- RMW_WR:
  - mem_write=1, mem_writedata = captured word with only the addressed byte/half replaced. -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_rd and resp_fault. -> IDLE, where req_ready returns to 1.
- Latency (accept edge to resp_valid high):
  - fault 1 cycle; load 2; word store 2; sub-word store 3.
- Never more than one strobe high; mem_read and mem_write are never high together.
- mem_address and mem_writedata hold their last value when no strobe is high.
- Reset mid-operation:
  - At the reset edge, state -> IDLE and the strobes deassert.
  - The pending request is dropped and no response is issued, even if reset hits in RMW_RD (no write occurs).
- Reset wins over a simultaneous req_valid.

Test Plan:
- Memory preloaded with mem[i]=i*10. Word load addr 0x14 -> mem_read pulse at index 5, resp_valid 2 cycles after accept, resp_rdata=0x00000032, resp_fault=0, resp_rd echoed.
- Byte load, signed, addr 0x34 (index 13 = 0x82) -> resp_rdata=0xFFFFFF82; same with req_unsigned=1 -> 0x00000082.
- Byte store 0xAB to addr 0x29 (index 10 = 0x64) -> RMW_RD read then a single mem_write with mem_writedata=0x0000AB64; response at 3 cycles; reload of index 10 returns 0x0000AB64.
- Half load addr 0x03, word store addr 0x200 (index 128), size 11 -> each gives resp_fault=1, resp_rdata=0, no mem_read/mem_write pulse, response 1 cycle after accept.
- Assert reset during RMW_RD of a byte store -> no mem_write ever, resp_valid stays 0, req_ready=1 the cycle after reset deasserts.
- Back-to-back req_valid held high -> req_ready low while busy; requests accepted only from IDLE; responses in order.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end between the EX/MEM register and a word-addressed data memory.
// Accepts one request at a time, performs sub-word stores as read-modify-write, extends sub-word
// loads, and faults misaligned, illegal-size or out-of-range accesses without touching memory.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only while idle)
//   req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd   request fields
//   resp_valid, resp_rdata, resp_rd, resp_fault                     one-cycle response
//   mem_read, mem_write, mem_address, mem_writedata, mem_readdata   data memory interface
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [2:0] {StIdle, StLoad, StStWord, StRmwRd, StRmwWr, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [15:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        resp_fault_q, resp_fault_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;

    logic        fault;
    logic [4:0]  shamt;
    logic [31:0] lane_mask, shifted, load_ext, merged;

    // Fault decode on the incoming request.
    always_comb begin
        fault = 1'b0;
        unique case (req_size)
            2'b00:   fault = 1'b0;
            2'b01:   fault = req_addr[0];
            2'b10:   fault = |req_addr[1:0];
            default: fault = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS) begin
            fault = 1'b1;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores (little-endian lanes).
    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        unique case (size_q)
            2'b00: begin
                shamt     = {lane_q, 3'b000};
                lane_mask = 32'h0000_00FF;
            end
            2'b01: begin
                shamt     = {lane_q[1], 4'b0000};
                lane_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
        shifted  = mem_readdata >> shamt;
        load_ext = shifted;
        unique case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        merged = (mem_readdata & ~(lane_mask << shamt)) | (({16'b0, wdata_q} & lane_mask) << shamt);
    end

    always_comb begin
        state_d         = state_q;
        lane_d          = lane_q;
        size_d          = size_q;
        uns_d           = uns_q;
        wdata_d         = wdata_q;
        rd_d            = rd_q;
        resp_rdata_d    = resp_rdata_q;
        resp_rd_d       = resp_rd_q;
        resp_fault_d    = resp_fault_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    lane_d  = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata[15:0];
                    rd_d    = req_rd;
                    if (fault) begin
                        state_d      = StResp;
                        resp_rdata_d = 32'd0;
                        resp_rd_d    = req_rd;
                        resp_fault_d = 1'b1;
                    end else begin
                        mem_address_d = {2'b00, req_addr[31:2]};
                        if (req_load) begin
                            state_d = StLoad;
                        end else if (req_size == 2'b10) begin
                            state_d         = StStWord;
                            mem_writedata_d = req_wdata;
                        end else begin
                            state_d = StRmwRd;
                        end
                    end
                end
            end
            StLoad: begin
                state_d      = StResp;
                resp_rdata_d = load_ext;
                resp_rd_d    = rd_q;
                resp_fault_d = 1'b0;
            end
            StRmwRd: begin
                state_d         = StRmwWr;
                mem_writedata_d = merged;
            end
            StStWord, StRmwWr: begin
                state_d      = StResp;
                resp_rdata_d = 32'd0;
                resp_rd_d    = rd_q;
                resp_fault_d = 1'b0;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Strobes and handshake are registered from the next state so they are glitch-free.
        req_ready_d  = (state_d == StIdle);
        resp_valid_d = (state_d == StResp);
        mem_read_d   = (state_d == StLoad) || (state_d == StRmwRd);
        mem_write_d  = (state_d == StStWord) || (state_d == StRmwWr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            lane_q          <= 2'd0;
            size_q          <= 2'd0;
            uns_q           <= 1'b0;
            wdata_q         <= 16'd0;
            rd_q            <= 5'd0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'd0;
            resp_rd_q       <= 5'd0;
            resp_fault_q    <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= 32'd0;
            mem_writedata_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            lane_q          <= lane_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            wdata_q         <= wdata_d;
            rd_q            <= rd_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_rd_q       <= resp_rd_d;
            resp_fault_q    <= resp_fault_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_rd       = resp_rd_q;
    assign resp_fault    = resp_fault_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_load, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_load     (req_load),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_rd      (resp_rd),
        .resp_fault   (resp_fault),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata)
    );

    // Data memory: combinational read, write while mem_write is high at a clock edge.
    logic [31:0] mem [MEM_WORDS];
    assign mem_readdata = (mem_address < MEM_WORDS) ? mem[mem_address[6:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (mem_write && mem_address < MEM_WORDS) mem[mem_address[6:0]] <= mem_writedata;
    end

    // Reference model: a plain byte array.
    logic [7:0] ref_b [MEM_WORDS*4];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          reads;
        int          writes;
        int          idx;
        int          accept;
        logic        has_const;
        logic [31:0] const_rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   rd_seen = 0;
    int   wr_seen = 0;
    bit   normal = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t predict(input logic ld, input logic [1:0] size, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int nbytes;
        logic [31:0] val;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e.idx = int'(addr >> 2);
        e.rdata = 32'd0;
        e.reads = 0;
        e.writes = 0;
        e.has_const = 1'b0;
        e.const_rdata = 32'd0;
        e.fault = (size == 2'd3) || ((addr % nbytes) != 0) || ((addr >> 2) >= MEM_WORDS);
        if (e.fault) begin
            e.lat = 1;
        end else if (ld) begin
            val = 32'd0;
            for (int k = 0; k < nbytes; k++) val = val | (32'(ref_b[int'(addr) + k]) << (8 * k));
            if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
            e.rdata = val;
            e.lat = 2;
            e.reads = 1;
        end else begin
            for (int k = 0; k < nbytes; k++) ref_b[int'(addr) + k] = 8'(wdata >> (8 * k));
            e.lat = (nbytes == 4) ? 2 : 3;
            e.reads = (nbytes == 4) ? 0 : 1;
            e.writes = 1;
        end
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (reset || !normal) begin
            rd_seen = 0;
            wr_seen = 0;
        end else begin
            if (mem_read || mem_write) begin
                check("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
                if (sb.size() == 0) check("stray_strobe", 32'(mem_read | mem_write), 32'd0);
                else check("strobe_addr", mem_address, 32'(sb[0].idx));
                if (mem_read) rd_seen++;
                if (mem_write) wr_seen++;
            end
            check("req_ready", 32'(req_ready), 32'(sb.size() == 0));
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("stray_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_rd", 32'(resp_rd), 32'(e.rd));
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_fault", 32'(resp_fault), 32'(e.fault));
                    check("latency", 32'(cyc - e.accept + 1), 32'(e.lat));
                    check("read_pulses", 32'(rd_seen), 32'(e.reads));
                    check("write_pulses", 32'(wr_seen), 32'(e.writes));
                    if (e.has_const) check("directed_rdata", resp_rdata, e.const_rdata);
                end
                rd_seen = 0;
                wr_seen = 0;
            end
        end
    end

    task automatic issue(input logic ld, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic has_const, input logic [31:0] const_rdata);
        exp_t e;
        int guard;
        @(negedge clk);
        req_valid    = 1'b1;
        req_load     = ld;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            e = predict(ld, size, uns, addr, wdata);
            e.rd = rd;
            e.accept = cyc + 1;
            e.has_const = has_const;
            e.const_rdata = const_rdata;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            idle();
            guard++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) idle();
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int r;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i] = 32'(i * 10);
            for (int k = 0; k < 4; k++) ref_b[i*4 + k] = 8'(32'(i * 10) >> (8 * k));
        end
        reset = 1'b1;
        req_valid = 1'b0;
        req_load = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_rd = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_rd", 32'(resp_rd), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_writedata", mem_writedata, 32'd0);
        reset = 1'b0;
        normal = 1'b1;
        idle();

        // Directed cases with fixed expected data.
        issue(1'b1, 2'd2, 1'b0, 32'h14, 32'd0, 5'd3, 1'b1, 32'h0000_0032);
        issue(1'b1, 2'd0, 1'b0, 32'h34, 32'd0, 5'd4, 1'b1, 32'hFFFF_FF82);
        issue(1'b1, 2'd0, 1'b1, 32'h34, 32'd0, 5'd5, 1'b1, 32'h0000_0082);
        issue(1'b0, 2'd0, 1'b0, 32'h29, 32'h1234_56AB, 5'd6, 1'b1, 32'd0);
        issue(1'b1, 2'd2, 1'b0, 32'h28, 32'd0, 5'd7, 1'b1, 32'h0000_AB64);
        issue(1'b1, 2'd1, 1'b0, 32'h03, 32'd0, 5'd8, 1'b1, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h5555_5555, 5'd9, 1'b1, 32'd0);
        issue(1'b1, 2'd3, 1'b0, 32'h10, 32'd0, 5'd10, 1'b1, 32'd0);
        drain();

        // Reset during RMW_RD of a byte store: request is dropped, nothing is written.
        normal = 1'b0;
        req_valid = 1'b1;
        req_load = 1'b0;
        req_size = 2'd0;
        req_addr = 32'h31;
        req_wdata = 32'h0000_00CD;
        req_rd = 5'd11;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_rd_entered", 32'(mem_read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_write", 32'(mem_write), 32'd0);
        check("rst_mid_mem_read", 32'(mem_read), 32'd0);
        check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_mem_write", 32'(mem_write), 32'd0);
            check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
            check("post_rst_req_ready", 32'(req_ready), 32'd1);
        end

        // Reset wins over a simultaneous request.
        req_valid = 1'b1;
        req_load = 1'b1;
        req_size = 2'd2;
        req_addr = 32'h40;
        reset = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        check("rst_wins_ready", 32'(req_ready), 32'd1);
        check("rst_wins_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        normal = 1'b1;
        idle();

        // Randomized traffic, frequently back-to-back with req_valid held high.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r = int'($urandom_range(0, 19));
            if (r == 0) a = 32'h200 + 32'($urandom_range(0, 63));
            else if (r == 1) a = $urandom();
            else a = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
                  5'($urandom_range(0, 31)), 1'b0, 32'd0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        drain();

        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            check("mem_final", mem[i], {ref_b[i*4+3], ref_b[i*4+2], ref_b[i*4+1], ref_b[i*4]});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
